// File: rtl/dc_mq.sv
// dc_mq: CH_N independent FIFO channels behind one push port, drained by a round-robin
// arbiter with a grant lock. Define DC_MQ_OCCUPANCY_EN to expose per-channel counts on occ.
module dc_mq #(
  parameter int CH_N  = 4,
  parameter int W     = 32,
  parameter int DEPTH = 8,
  parameter int CH_W  = $clog2(CH_N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_vld,
  input  logic [CH_W-1:0] push_ch,
  input  logic [W-1:0]    push_dat,
  output logic            push_rdy,
  output logic            out_vld,
  output logic [CH_W-1:0] out_ch,
  output logic [W-1:0]    out_dat,
  input  logic            out_rdy
`ifdef DC_MQ_OCCUPANCY_EN
  ,
  output logic [CH_N*($clog2(DEPTH)+1)-1:0] occ
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem    [CH_N][DEPTH];
  logic [PTR_W-1:0] wr_ptr [CH_N];
  logic [PTR_W-1:0] rd_ptr [CH_N];
  logic [CNT_W-1:0] count  [CH_N];
  logic [CH_W-1:0]  rr_ptr;
  logic             lock_vld;
  logic [CH_W-1:0]  lock_ch;

  logic             ch_in_range;
  logic [CNT_W-1:0] sel_cnt;
  logic             push_ok;
  logic             pop_ok;
  logic [CH_N-1:0]  push_hit;
  logic [CH_N-1:0]  pop_hit;
  logic [CH_N-1:0]  non_empty;
  logic             hi_found;
  logic             lo_found;
  logic [CH_W-1:0]  hi_ch;
  logic [CH_W-1:0]  lo_ch;
  logic [CH_W-1:0]  cand_ch;
  logic [CH_W-1:0]  grant_ch;
  logic [W-1:0]     head_dat;

  // Push acceptance looks only at registered counts, so a full channel never
  // accepts even when it is being popped in the same cycle.
  always_comb begin
    ch_in_range = 1'b0;
    sel_cnt     = '0;
    for (int c = 0; c < CH_N; c++) begin
      if (push_ch == CH_W'(c)) begin
        ch_in_range = 1'b1;
        sel_cnt     = count[c];
      end
    end
    push_rdy = ch_in_range && (sel_cnt != CNT_W'(DEPTH));
    push_ok  = push_vld && push_rdy;
  end

  // Round-robin candidate: first non-empty channel above rr_ptr, else the
  // lowest non-empty channel at or below it (the wrap-around part of the search).
  always_comb begin
    non_empty = '0;
    hi_found  = 1'b0;
    lo_found  = 1'b0;
    hi_ch     = '0;
    lo_ch     = '0;
    for (int c = 0; c < CH_N; c++) begin
      non_empty[c] = (count[c] != '0);
      if (non_empty[c]) begin
        if (CH_W'(c) > rr_ptr) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_ch    = CH_W'(c);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_ch    = CH_W'(c);
        end
      end
    end
    cand_ch  = hi_found ? hi_ch : lo_ch;
    grant_ch = lock_vld ? lock_ch : cand_ch;
  end

  always_comb begin
    out_vld  = |non_empty;
    head_dat = '0;
    for (int c = 0; c < CH_N; c++) begin
      if (grant_ch == CH_W'(c)) head_dat = mem[c][rd_ptr[c]];
    end
    out_ch  = out_vld ? grant_ch : '0;
    out_dat = out_vld ? head_dat : '0;
    pop_ok  = out_vld && out_rdy;
    push_hit = '0;
    pop_hit  = '0;
    for (int c = 0; c < CH_N; c++) begin
      push_hit[c] = push_ok && (push_ch == CH_W'(c));
      pop_hit[c]  = pop_ok && (out_ch == CH_W'(c));
    end
  end

  // rr_ptr starts at the last channel so the first grant after reset is channel 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CH_N; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
      rr_ptr   <= CH_W'(CH_N - 1);
      lock_vld <= 1'b0;
      lock_ch  <= '0;
    end else begin
      for (int c = 0; c < CH_N; c++) begin
        if (push_hit[c]) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
        if (pop_hit[c])  rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
        if (push_hit[c] && !pop_hit[c]) begin
          count[c] <= count[c] + CNT_W'(1);
        end else if (!push_hit[c] && pop_hit[c]) begin
          count[c] <= count[c] - CNT_W'(1);
        end
      end
      if (pop_ok) begin
        rr_ptr   <= out_ch;
        lock_vld <= 1'b0;
      end else if (out_vld) begin
        lock_vld <= 1'b1;
        lock_ch  <= grant_ch;
      end
    end
  end

  // Payload storage carries no reset; only the control state above is cleared.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CH_N; c++) begin
      if (push_hit[c] && !rst) mem[c][wr_ptr[c]] <= push_dat;
    end
  end

`ifdef DC_MQ_OCCUPANCY_EN
  always_comb begin
    occ = '0;
    for (int c = 0; c < CH_N; c++) begin
      occ[c*CNT_W +: CNT_W] = count[c];
    end
  end
`endif

endmodule

// File: doc/dc_mq.md
# dc_mq

Parametrised multi-channel queue for the `dc` subsystem. It holds CH_N independent FIFO channels in partitioned storage behind one shared push port. A round-robin arbiter drains all channels through one shared pop port. This block generalises the single-queue `dc` into a configurable channel count, depth and data width, and adds fair arbitration with a grant lock.

## Interface
Parameters:
- CH_N, 4, number of channels; must be ≥2
- W, 32, data width in bits
- DEPTH, 8, entries per channel; must be a power of 2 and ≥2
- CH_W, $clog2(CH_N), derived channel-index width; do not override

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- push_vld  in  1  push request
- push_ch  in  CH_W  target channel of the push
- push_dat  in  W  push payload
- push_rdy  out  1  push accepted when push_vld && push_rdy
- out_vld  out  1  head entry available
- out_ch  out  CH_W  channel of the presented entry
- out_dat  out  W  presented payload
- out_rdy  in  1  consumer accepts when out_vld && out_rdy
- occ  out  CH_N*($clog2(DEPTH)+1)  per-channel occupancy, channel 0 in the LSBs; present only under DC_MQ_OCCUPANCY_EN

## Operation
- Per-channel state:
  - write pointer and read pointer, each $clog2(DEPTH) bits, wrapping modulo DEPTH
  - count, $clog2(DEPTH)+1 bits, range 0..DEPTH
  - storage of CH_N×DEPTH×W
- Push:
  - push_rdy = (push_ch < CH_N) && count[push_ch] != DEPTH.
  - push_rdy depends only on current state and push_ch. It never depends on same-cycle pop, so there is no pass-through when a channel is full.
  - A push with push_ch ≥ CH_N (non-power-of-2 CH_N) is refused and not stored.
- Arbitration:
  - rr_ptr holds the last granted channel.
  - The candidate is the first non-empty channel strictly after rr_ptr, searching upward and wrapping.
  - out_vld = any channel non-empty.
- Grant lock:
  - When out_vld && !out_rdy, the grant is registered into lock_ch and lock_vld is set.
  - While lock_vld is set, out_ch = lock_ch, overriding the candidate. out_ch and out_dat then stay stable until the entry is accepted.
  - lock_vld clears on acceptance.
- Pop: on out_vld && out_rdy:
  - the read pointer of out_ch increments
  - count of out_ch decrements
  - rr_ptr <= out_ch
- Same channel push and pop in one cycle: count is unchanged and both pointers advance. This is legal at any count 1..DEPTH-1. At count DEPTH the push is refused.
- Empty channel push: the entry is visible no earlier than the next cycle. There is no empty bypass.
- out_* are driven from registered state only. There is no combinational path from push_* or out_rdy to out_vld, out_ch or out_dat.
- When out_vld=0, out_ch and out_dat are 0.

## Timing
- Reset state (rst=1 at an edge): all counts and pointers are 0, rr_ptr=CH_N-1, lock_vld=0. The first grant therefore goes to channel 0.
- Output values in the cycle after reset:
  - out_vld=0, out_ch=0, out_dat=0
  - push_rdy=1 for any valid push_ch
  - occ=0
- Reset mid-operation discards all contents in one cycle. A handshake in the reset cycle has no effect.
- Push-to-pop latency is 1 cycle: a push at edge t allows out_vld=1 from t+1 and a pop at edge t+1.
- Throughput is one push and one pop per cycle, on any channels.
- Storage contents are not reset. Only control state is.

## Configuration
- DC_MQ_OCCUPANCY_EN
  - Defined: the occ port exists and carries each registered channel count.
  - Undefined: the port and its logic are omitted and the queue behaviour is otherwise identical.

## Test plan
- Reset with storage pre-filled by pushes, then rst=1 for 1 cycle -> out_vld=0, all push_rdy=1, occ=0; a push of 0xA5 on ch2 appears with out_ch=2 one cycle later.
- Fill ch1 with DEPTH=8 entries 0..7 while out_rdy=0 -> push_rdy=0 on ch1 at count 8, push_rdy=1 on ch0; draining yields 0..7 in order and pointers wrap.
- Channels 0, 1 and 3 each hold 2 entries with out_rdy=1 -> pop order ch0, ch1, ch3, ch0, ch1, ch3.
- Stall while out_ch=3 (out_rdy=0), then push to ch0 -> out_ch stays 3 with out_dat stable until accepted; the next grant is ch0.
- Ch2 at count 4 with simultaneous push and pop of ch2 -> count stays 4 and FIFO order is preserved; ch2 at count 8 with push and pop -> push refused and count becomes 7.
- Non-power-of-2 CH_N=3 with a push to ch 3 -> push_rdy=0 and nothing is stored. Build with and without DC_MQ_OCCUPANCY_EN -> identical pop traces.
